// File: rtl/fas_tol_checker.sv
// fas_tol_checker: compares a DUT output beat (LANES samples) against a golden
// beat. Each component must be within a signed tolerance window, and the
// difference is taken modulo 2^DW. The checker counts mismatching samples,
// aborts at FAIL_LIMIT and records the first error location.
// Optional feature: define FAS_CHK_FIRST_ERR_DATA_EN to add first_err_dut and
// first_err_gold, which hold the samples of the first mismatching lane.
//
// Handshake: in_valid is a one-cycle beat strobe with no back-pressure.
// dut_data and gold_data are sampled on every rising edge where in_valid=1.
// Status for a beat becomes visible two rising edges after the beat is sampled.
module fas_tol_checker #(
    parameter int LANES       = 16,
    parameter int DW          = 16,
    parameter int COMPLEX     = 1,
    parameter int TOL         = 3,
    parameter int FAIL_LIMIT  = 48,
    parameter int TOTAL_BEATS = 64,
    parameter int CNT_W       = 16,
    localparam int SW = DW * (COMPLEX + 1),
    localparam int BW = $clog2(TOTAL_BEATS + 1),
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   in_valid,
    input  logic [LANES*SW-1:0]    dut_data,
    input  logic [LANES*SW-1:0]    gold_data,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   abort,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [BW-1:0]          beat_cnt,
    output logic [LANES-1:0]       err_mask,
    output logic                   first_err_valid,
    output logic [BW-1:0]          first_err_beat,
    output logic [LW-1:0]          first_err_lane,
`ifdef FAS_CHK_FIRST_ERR_DATA_EN
    output logic [SW-1:0]          first_err_dut,
    output logic [SW-1:0]          first_err_gold,
`endif
    output logic [1:0]             dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_ABORT = 2'd3;

    localparam logic signed [DW-1:0] TOL_POS = DW'(TOL);
    localparam logic signed [DW-1:0] TOL_NEG = -TOL_POS;

    // A component fails when (gold - dut) mod 2^DW, read as signed, leaves the window.
    function automatic logic comp_bad(input logic [DW-1:0] g, input logic [DW-1:0] d);
        logic signed [DW-1:0] diff;
        diff = g - d;
        return (diff > TOL_POS) || (diff < TOL_NEG);
    endfunction

    logic [1:0]       state_q, state_d;
    logic [LANES-1:0] mask_d;
    logic [LW-1:0]    lane_d;
    logic             s1_valid_d;
    logic             s1_valid_q;
    logic [LANES-1:0] s1_mask_q;
    logic [LW-1:0]    s1_lane_q;
    logic [CNT_W-1:0] err_cnt_q, err_next;
    logic [CNT_W:0]   pop, err_sum;
    logic [BW-1:0]    beat_cnt_q, beat_next;
    logic [LANES-1:0] err_mask_q;
    logic             fev_q;
    logic [BW-1:0]    fbeat_q;
    logic [LW-1:0]    flane_q;
    logic             upd, abort_hit, last_hit;

`ifdef FAS_CHK_FIRST_ERR_DATA_EN
    logic [SW-1:0]    s1_dut_d, s1_gold_d, s1_dut_q, s1_gold_q;
    logic [SW-1:0]    fdut_q, fgold_q;
`endif

    // Per-lane mismatch: real component in the upper DW bits, imag in the lower.
    always_comb begin
        mask_d = '0;
        for (int i = 0; i < LANES; i++) begin
            mask_d[i] = comp_bad(gold_data[i*SW + SW - DW +: DW], dut_data[i*SW + SW - DW +: DW]);
            if (COMPLEX != 0) begin
                mask_d[i] = mask_d[i] | comp_bad(gold_data[i*SW +: DW], dut_data[i*SW +: DW]);
            end
        end
    end

    // Lowest mismatching lane of the incoming beat (scan down so the lowest wins).
    always_comb begin
        lane_d = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask_d[i]) lane_d = LW'(i);
        end
    end

`ifdef FAS_CHK_FIRST_ERR_DATA_EN
    // Samples of the lowest mismatching lane, carried through stage 1.
    always_comb begin
        s1_dut_d  = dut_data[int'(lane_d)*SW +: SW];
        s1_gold_d = gold_data[int'(lane_d)*SW +: SW];
    end
`endif

    // Beats are only accepted while a run can still consume them.
    assign s1_valid_d = in_valid && ((state_q == ST_IDLE) || (state_q == ST_RUN));

    // Stage 1: register the mismatch vector and its valid bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_mask_q  <= '0;
            s1_lane_q  <= '0;
`ifdef FAS_CHK_FIRST_ERR_DATA_EN
            s1_dut_q   <= '0;
            s1_gold_q  <= '0;
`endif
        end else if (clr) begin
            s1_valid_q <= 1'b0;
            s1_mask_q  <= '0;
            s1_lane_q  <= '0;
`ifdef FAS_CHK_FIRST_ERR_DATA_EN
            s1_dut_q   <= '0;
            s1_gold_q  <= '0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            if (s1_valid_d) begin
                s1_mask_q <= mask_d;
                s1_lane_q <= lane_d;
`ifdef FAS_CHK_FIRST_ERR_DATA_EN
                s1_dut_q  <= s1_dut_d;
                s1_gold_q <= s1_gold_d;
`endif
            end
        end
    end

    // Stage 2 arithmetic: saturating error count, beat count and end-of-run tests.
    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++) begin
            pop = pop + (CNT_W + 1)'(s1_mask_q[i]);
        end
        err_sum   = {1'b0, err_cnt_q} + pop;
        err_next  = err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
        beat_next = beat_cnt_q + BW'(1);
        upd       = s1_valid_q && (state_q == ST_RUN);
        abort_hit = ({1'b0, err_next} >= (CNT_W + 1)'(FAIL_LIMIT));
        last_hit  = (beat_next == BW'(TOTAL_BEATS));
    end

    // Run FSM: starts on the first accepted beat; abort takes priority over the last beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_RUN;
            ST_RUN: begin
                if (upd) begin
                    if (abort_hit)     state_d = ST_ABORT;
                    else if (last_hit) state_d = ST_DONE;
                end
            end
            default: state_d = state_q;
        endcase
    end

    // Stage 2: status registers, updated once per checked beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            err_cnt_q  <= '0;
            beat_cnt_q <= '0;
            err_mask_q <= '0;
            fev_q      <= 1'b0;
            fbeat_q    <= '0;
            flane_q    <= '0;
`ifdef FAS_CHK_FIRST_ERR_DATA_EN
            fdut_q     <= '0;
            fgold_q    <= '0;
`endif
        end else if (clr) begin
            state_q    <= ST_IDLE;
            err_cnt_q  <= '0;
            beat_cnt_q <= '0;
            err_mask_q <= '0;
            fev_q      <= 1'b0;
            fbeat_q    <= '0;
            flane_q    <= '0;
`ifdef FAS_CHK_FIRST_ERR_DATA_EN
            fdut_q     <= '0;
            fgold_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (upd) begin
                err_cnt_q  <= err_next;
                beat_cnt_q <= beat_next;
                err_mask_q <= s1_mask_q;
                if (!fev_q && (|s1_mask_q)) begin
                    fev_q   <= 1'b1;
                    fbeat_q <= beat_cnt_q;
                    flane_q <= s1_lane_q;
`ifdef FAS_CHK_FIRST_ERR_DATA_EN
                    fdut_q  <= s1_dut_q;
                    fgold_q <= s1_gold_q;
`endif
                end
            end
        end
    end

    assign busy            = (state_q == ST_RUN);
    assign done            = (state_q == ST_DONE) || (state_q == ST_ABORT);
    assign abort           = (state_q == ST_ABORT);
    assign pass            = (state_q == ST_DONE) && (err_cnt_q == '0);
    assign err_cnt         = err_cnt_q;
    assign beat_cnt        = beat_cnt_q;
    assign err_mask        = err_mask_q;
    assign first_err_valid = fev_q;
    assign first_err_beat  = fbeat_q;
    assign first_err_lane  = flane_q;
    assign dbg_state       = state_q;
`ifdef FAS_CHK_FIRST_ERR_DATA_EN
    assign first_err_dut   = fdut_q;
    assign first_err_gold  = fgold_q;
`endif

endmodule

// File: tb/tb_fas_tol_checker.sv
// Self-checking bench for fas_tol_checker: an FFT-style instance (16 complex
// lanes) driven through a scoreboard, plus an FIR-style instance (1 real lane).
module tb_fas_tol_checker;

    localparam int L    = 16;
    localparam int S    = 32;
    localparam int DWA  = L * S;
    localparam int BWF  = 7;
    localparam int FBW  = 11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- FFT-style instance ----------------
    logic            clr = 1'b0;
    logic            in_valid = 1'b0;
    logic [DWA-1:0]  dut_data = '0;
    logic [DWA-1:0]  gold_data = '0;
    logic            busy, done, pass, abort_o;
    logic [15:0]     err_cnt;
    logic [BWF-1:0]  beat_cnt;
    logic [L-1:0]    err_mask;
    logic            fev;
    logic [BWF-1:0]  fbeat;
    logic [3:0]      flane;
    logic [1:0]      dbg_state;
`ifdef FAS_CHK_FIRST_ERR_DATA_EN
    logic [S-1:0]    fdut, fgold;
`endif

    fas_tol_checker u_fft (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
        .dut_data(dut_data), .gold_data(gold_data),
        .busy(busy), .done(done), .pass(pass), .abort(abort_o),
        .err_cnt(err_cnt), .beat_cnt(beat_cnt), .err_mask(err_mask),
        .first_err_valid(fev), .first_err_beat(fbeat), .first_err_lane(flane),
`ifdef FAS_CHK_FIRST_ERR_DATA_EN
        .first_err_dut(fdut), .first_err_gold(fgold),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- FIR-style instance ----------------
    logic            f_clr = 1'b0;
    logic            f_valid = 1'b0;
    logic [15:0]     f_dut = '0;
    logic [15:0]     f_gold = '0;
    logic            f_busy, f_done, f_pass, f_abort;
    logic [15:0]     f_err_cnt;
    logic [FBW-1:0]  f_beat_cnt;
    logic [0:0]      f_err_mask;
    logic            f_fev;
    logic [FBW-1:0]  f_fbeat;
    logic [0:0]      f_flane;
    logic [1:0]      f_dbg_state;
`ifdef FAS_CHK_FIRST_ERR_DATA_EN
    logic [15:0]     f_fdut, f_fgold;
`endif

    fas_tol_checker #(
        .LANES(1), .DW(16), .COMPLEX(0), .TOL(1), .FAIL_LIMIT(48),
        .TOTAL_BEATS(1024), .CNT_W(16)
    ) u_fir (
        .clk(clk), .rst(rst), .clr(f_clr), .in_valid(f_valid),
        .dut_data(f_dut), .gold_data(f_gold),
        .busy(f_busy), .done(f_done), .pass(f_pass), .abort(f_abort),
        .err_cnt(f_err_cnt), .beat_cnt(f_beat_cnt), .err_mask(f_err_mask),
        .first_err_valid(f_fev), .first_err_beat(f_fbeat), .first_err_lane(f_flane),
`ifdef FAS_CHK_FIRST_ERR_DATA_EN
        .first_err_dut(f_fdut), .first_err_gold(f_fgold),
`endif
        .dbg_state(f_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [38:0] exp_q[$];   // {mask[15:0], err_cnt[15:0], beat_cnt[6:0]}
    logic        p1 = 1'b0;  // a scoreboard entry becomes due after the next edge

    // Reference model state (0 idle, 1 run, 2 done, 3 abort)
    int m_state = 0;
    int m_err   = 0;
    int m_beat  = 0;
    int m_fev   = 0;
    int m_fbeat = 0;
    int m_flane = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Independent tolerance model using integer arithmetic.
    function automatic bit comp_bad_m(input logic [15:0] g, input logic [15:0] d, input int tol);
        int diff;
        diff = (int'(g) - int'(d) + 65536) % 65536;
        if (diff >= 32768) diff = diff - 65536;
        return (diff > tol) || (diff < -tol);
    endfunction

    task automatic model_clear();
        m_state = 0; m_err = 0; m_beat = 0;
        m_fev = 0; m_fbeat = 0; m_flane = 0;
        exp_q.delete();
        p1 = 1'b0;
    endtask

    task automatic model_beat(input logic [DWA-1:0] d, input logic [DWA-1:0] g, output logic pushed);
        logic [15:0] mask;
        int pc;
        pushed = 1'b0;
        if (m_state >= 2) return;
        m_state = 1;
        mask = '0;
        pc = 0;
        for (int i = 0; i < L; i++) begin
            if (comp_bad_m(g[i*S+16 +: 16], d[i*S+16 +: 16], 3) ||
                comp_bad_m(g[i*S +: 16], d[i*S +: 16], 3)) begin
                mask[i] = 1'b1;
                pc++;
            end
        end
        if (m_fev == 0 && pc != 0) begin
            m_fev = 1;
            m_fbeat = m_beat;
            m_flane = -1;
            for (int i = 0; i < L; i++) if (mask[i] && m_flane < 0) m_flane = i;
        end
        m_err = (m_err + pc > 65535) ? 65535 : m_err + pc;
        m_beat++;
        if (m_err >= 48) m_state = 3;
        else if (m_beat == 64) m_state = 2;
        exp_q.push_back({mask, 16'(m_err), 7'(m_beat)});
        pushed = 1'b1;
    endtask

    // One clock: drive inputs, push expectation, then compare anything due.
    task automatic tick(input logic v, input logic c, input logic [DWA-1:0] d, input logic [DWA-1:0] g);
        logic pushed;
        logic [38:0] e;
        in_valid = v; clr = c; dut_data = d; gold_data = g;
        pushed = 1'b0;
        if (c) model_clear();
        else if (v) model_beat(d, g, pushed);
        @(posedge clk); #1;
        in_valid = 1'b0; clr = 1'b0;
        if (p1) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_err_mask", 64'(err_mask), 64'(e[38:23]));
                chk("sb_err_cnt",  64'(err_cnt),  64'(e[22:7]));
                chk("sb_beat_cnt", 64'(beat_cnt), 64'(e[6:0]));
            end
        end
        p1 = pushed;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, '0);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_busy"},  64'(busy),    64'(m_state == 1));
        chk({tag, "_done"},  64'(done),    64'(m_state >= 2));
        chk({tag, "_abort"}, 64'(abort_o), 64'(m_state == 3));
        chk({tag, "_pass"},  64'(pass),    64'(m_state == 2 && m_err == 0));
        chk({tag, "_err"},   64'(err_cnt), 64'(m_err));
        chk({tag, "_beat"},  64'(beat_cnt), 64'(m_beat));
        chk({tag, "_fev"},   64'(fev),     64'(m_fev));
        if (m_fev != 0) begin
            chk({tag, "_fbeat"}, 64'(fbeat), 64'(m_fbeat));
            chk({tag, "_flane"}, 64'(flane), 64'(m_flane));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  64'(busy),     0);
        chk({tag, "_done"},  64'(done),     0);
        chk({tag, "_pass"},  64'(pass),     0);
        chk({tag, "_abort"}, 64'(abort_o),  0);
        chk({tag, "_err"},   64'(err_cnt),  0);
        chk({tag, "_beat"},  64'(beat_cnt), 0);
        chk({tag, "_mask"},  64'(err_mask), 0);
        chk({tag, "_fev"},   64'(fev),      0);
        chk({tag, "_fbeat"}, 64'(fbeat),    0);
        chk({tag, "_flane"}, 64'(flane),    0);
    endtask

    function automatic logic [DWA-1:0] rand_beat();
        logic [DWA-1:0] b;
        for (int i = 0; i < L; i++) b[i*S +: S] = $urandom();
        return b;
    endfunction

    // Watchdog: the directed sequence is bounded, this only catches a stuck run.
    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [DWA-1:0] g, d;
        logic [15:0] fg;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Exact match run: 64 identical beats -> pass
        for (int b = 0; b < 64; b++) begin
            g = rand_beat();
            tick(1'b1, 1'b0, g, g);
            if (b == 0) chk("busy_after_first_beat", 64'(busy), 1);
        end
        idle(2);
        chk_model("exact");
        chk("exact_done", 64'(done), 1);
        chk("exact_pass", 64'(pass), 1);
        chk("exact_beat64", 64'(beat_cnt), 64);

        // clr and in_valid together: clr wins, the beat is dropped
        tick(1'b0, 1'b1, '0, '0);
        chk_zero("clr");
        g = rand_beat(); d = ~g;
        tick(1'b1, 1'b1, d, g);
        idle(2);
        chk_zero("clr_wins");

        // Tolerance edges: +3 / -3 pass, then +4 fails on lane 7
        g = rand_beat(); d = g;
        d[3*S+16 +: 16] = g[3*S+16 +: 16] + 16'd3;
        d[5*S +: 16]    = g[5*S +: 16] - 16'd3;
        tick(1'b1, 1'b0, d, g);
        g = rand_beat(); d = g;
        d[7*S+16 +: 16] = g[7*S+16 +: 16] + 16'd4;
        tick(1'b1, 1'b0, d, g);
`ifdef FAS_CHK_FIRST_ERR_DATA_EN
        fg = g[7*S+16 +: 16];
`else
        fg = '0;
`endif
        idle(2);
        chk("tol_err_cnt", 64'(err_cnt), 1);
        chk("tol_err_mask", 64'(err_mask), 64'h0080);
        chk("tol_fbeat", 64'(fbeat), 1);
        chk("tol_flane", 64'(flane), 7);
`ifdef FAS_CHK_FIRST_ERR_DATA_EN
        chk("tol_fgold_real", 64'(fgold[31:16]), 64'(fg));
        chk("tol_fdut_real", 64'(fdut[31:16]), 64'(fg + 16'd4));
`endif

        // Wrap compare: both wrap cases pass, 0x8000 vs 0x7FFC fails
        g = rand_beat(); d = g;
        g[0*S+16 +: 16] = 16'h0000; d[0*S+16 +: 16] = 16'hFFFF;
        g[1*S +: 16]    = 16'h7FFF; d[1*S +: 16]    = 16'h8001;
        tick(1'b1, 1'b0, d, g);
        g = rand_beat(); d = g;
        g[2*S+16 +: 16] = 16'h8000; d[2*S+16 +: 16] = 16'h7FFC;
        tick(1'b1, 1'b0, d, g);
        idle(2);
        chk("wrap_err_mask", 64'(err_mask), 64'h0004);
        chk("wrap_err_cnt", 64'(err_cnt), 2);
        chk_model("wrap");

        // Abort: all lanes bad, limit hit after beat 3, later beats ignored
        tick(1'b0, 1'b1, '0, '0);
        for (int b = 0; b < 10; b++) begin
            g = rand_beat(); d = g;
            for (int i = 0; i < L; i++) d[i*S+16 +: 16] = g[i*S+16 +: 16] + 16'd100;
            tick(1'b1, 1'b0, d, g);
        end
        idle(2);
        chk("abort_err_cnt", 64'(err_cnt), 48);
        chk("abort_flag", 64'(abort_o), 1);
        chk("abort_done", 64'(done), 1);
        chk("abort_pass", 64'(pass), 0);
        chk("abort_beat_cnt", 64'(beat_cnt), 3);
        chk_model("abort");

        // Async reset mid-run with a beat in flight
        tick(1'b0, 1'b1, '0, '0);
        for (int b = 0; b < 20; b++) begin
            g = rand_beat(); d = g;
            if (b % 4 == 1) d[(b % L)*S +: 16] = g[(b % L)*S +: 16] + 16'd9;
            tick(1'b1, 1'b0, d, g);
        end
        rst = 1'b0;
        #1;
        chk_zero("async_rst");
        model_clear();
        #3;
        rst = 1'b1;
        @(posedge clk); #1;
        g = rand_beat(); d = g;
        d[9*S +: 16] = g[9*S +: 16] - 16'd5;
        tick(1'b1, 1'b0, d, g);
        idle(2);
        chk("restart_fbeat", 64'(fbeat), 0);
        chk("restart_flane", 64'(flane), 9);
        chk_model("restart");

        // FIR mode: every 100th beat off by 2, others within +-1
        for (int b = 0; b < 1024; b++) begin
            fg = 16'($urandom());
            f_gold = fg;
            if (b % 100 == 99) f_dut = fg + 16'd2;
            else f_dut = (b % 2 == 1) ? fg - 16'd1 : fg + 16'd1;
            f_valid = 1'b1;
            @(posedge clk); #1;
            f_valid = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("fir_done", 64'(f_done), 1);
        chk("fir_pass", 64'(f_pass), 0);
        chk("fir_err_cnt", 64'(f_err_cnt), 10);
        chk("fir_beat_cnt", 64'(f_beat_cnt), 1024);
        chk("fir_fbeat", 64'(f_fbeat), 99);

        f_clr = 1'b1;
        @(posedge clk); #1;
        f_clr = 1'b0;
        chk("fir_clr_err", 64'(f_err_cnt), 0);
        chk("fir_clr_beat", 64'(f_beat_cnt), 0);
        chk("fir_clr_done", 64'(f_done), 0);
        for (int b = 0; b < 1024; b++) begin
            fg = 16'($urandom());
            f_gold = fg; f_dut = fg;
            f_valid = 1'b1;
            @(posedge clk); #1;
            f_valid = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("fir_rerun_pass", 64'(f_pass), 1);
        chk("fir_rerun_err", 64'(f_err_cnt), 0);
        chk("fir_rerun_fev", 64'(f_fev), 0);

        chk("sb_drained", 64'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fas_tol_checker.md
Name: fas_tol_checker

Overview:
- Synthesizable, parametrised output checker for the FAS datapath (FIR and FFT output streams).
- Compares a DUT beat of LANES samples against a golden beat, using a signed tolerance window with modular wrap.
- Accumulates per-sample mismatches and aborts at a configurable fail limit.
- Reports pass/fail status and first-error location; used on-chip (BIST) and in emulation in place of bench-only compare loops.

Parameters:
- LANES, 16, samples per beat (1 for FIR stream, 16 for FFT stream)
- DW, 16, width of one real component
- COMPLEX, 1, 1 = each sample is {real[DW], imag[DW]}; 0 = real only
- TOL, 3, allowed absolute difference per component, in LSBs (0..2^(DW-1)-1)
- FAIL_LIMIT, 48, error count that triggers abort (>=1)
- TOTAL_BEATS, 64, beats per run
- CNT_W, 16, error-counter width
- (derived) SW = DW*(COMPLEX+1); BW = clog2(TOTAL_BEATS+1); LW = clog2(LANES), minimum 1

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear to IDLE; same values as reset
- in_valid  in  1  beat strobe; dut_data and gold_data are valid this cycle
- dut_data  in  LANES*SW  DUT samples; lane n at [n*SW +: SW], real component in upper DW bits
- gold_data  in  LANES*SW  golden samples, same packing
- busy  out  1  run in progress
- done  out  1  sticky; run finished (all beats checked, or abort)
- pass  out  1  sticky; done with err_cnt==0
- abort  out  1  sticky; err_cnt reached FAIL_LIMIT
- err_cnt  out  CNT_W  mismatching samples so far, saturating
- beat_cnt  out  BW  beats checked so far
- err_mask  out  LANES  lanes that mismatched in the last checked beat
- first_err_valid  out  1  first_err_* fields are captured
- first_err_beat  out  BW  beat index of the first mismatch
- first_err_lane  out  LW  lowest mismatching lane in that beat

Behaviour:
- Reset/clr: state=IDLE; every output 0.
- Component compare: d = (gold - dut) mod 2^DW, interpreted as signed DW. The component passes iff -TOL <= d <= TOL.
  - Wrap example: gold 0x0000 vs dut 0xFFFF gives d=+1.
- Sample mismatch: any component fails; the imag component is ignored when COMPLEX=0.
- Pipeline: one register stage.
  - Stage 1 registers the per-lane mismatch vector and a valid bit.
  - Stage 2 updates err_mask, err_cnt, beat_cnt, first_err_* and state.
  - Every status update appears 2 clocks after the in_valid beat.
- FSM states: IDLE, RUN, DONE, ABORT.
  - IDLE -> RUN on the first in_valid. That beat is checked, and busy=1 from the next cycle.
  - RUN: each in_valid beat is checked and gaps are allowed.
    - err_cnt += popcount(mismatch), saturating at 2^CNT_W-1.
    - beat_cnt += 1.
  - RUN -> ABORT when the updated err_cnt >= FAIL_LIMIT. Outputs: abort=1, done=1, pass=0, busy=0.
  - RUN -> DONE when the updated beat_cnt == TOTAL_BEATS and there is no abort. Outputs: done=1, busy=0, pass=(err_cnt==0).
  - Abort and last beat on the same beat: ABORT wins.
  - DONE/ABORT: in_valid is ignored, including beats still in the stage-1 register. Outputs hold until clr or reset.
- err_mask: updated on every checked beat, including all-zero masks; holds between beats.
- first_err_*: captured on the first beat with a nonzero mask. first_err_lane is the lowest set lane; the fields never change afterwards.
- Async reset mid-run clears everything immediately; the in-flight stage-1 beat is discarded.
- clr and in_valid in the same cycle: clr wins and the beat is dropped.

Optional Feature:
- Macro FAS_CHK_FIRST_ERR_DATA_EN.
- Defined: adds outputs first_err_dut and first_err_gold, each SW wide. They hold the samples of first_err_lane, captured together with first_err_valid, and clear on reset/clr.
- Undefined: the ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Exact match (LANES=16, COMPLEX=1, TOL=3, TOTAL_BEATS=64): 64 beats with dut==gold.
  Expect done=1 and pass=1 at 2 clocks after beat 64; err_cnt=0, beat_cnt=64, first_err_valid=0.
- Tolerance edges, one beat:
  - lane3 real dut=gold+3, lane5 imag dut=gold-3 -> no error.
  - Next beat, lane7 real dut=gold+4 -> err_cnt=1, err_mask=0x0080, first_err_beat=1, first_err_lane=7.
- Wrap compare: gold=0x0000 vs dut=0xFFFF and gold=0x7FFF vs dut=0x8001, TOL=3 -> both pass.
  Next, gold=0x8000 vs dut=0x7FFC -> mismatch (d=+4).
- Abort (FAIL_LIMIT=48): 3 beats with all 16 lanes bad.
  Expect err_cnt=48, abort=1, done=1, pass=0 after beat 3; beats 4..10 leave err_cnt and beat_cnt unchanged.
- FIR mode (LANES=1, COMPLEX=0, TOL=1, TOTAL_BEATS=1024):
  - Every 100th beat off by 2 -> done with err_cnt=10, pass=0.
  - Repeat after clr: all counters 0 and a clean rerun passes.
- Async reset at beat 20 of 64 with errors pending -> all outputs 0 within the same cycle.
  A restarted run accepts beat 0 and the first_err capture resets.
